// File: rtl/rpn_pkg.sv
// Shared constants for the RPN sequencer: opcodes, FSM state encoding, error codes.
package rpn_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] PUSH_N = 3'd1;
   localparam logic [2:0] POP_A  = 3'd2;
   localparam logic [2:0] POP_B  = 3'd3;
   localparam logic [2:0] PUSH_R = 3'd4;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_UNDER = 2'd1;
   localparam logic [1:0] ERR_OVER  = 2'd2;
   localparam logic [1:0] ERR_BADOP = 2'd3;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_XOR;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// Shared LIFO stack; state advances on the falling clock edge, top of stack is combinational.
module lifo_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SW-1:0]    sp;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;

   assign full     = (sp == SW'(DEPTH));
   assign empty    = (sp == '0);
   assign top_idx  = AW'(sp - SW'(1));
   assign wr_idx   = AW'(sp);
   assign data_out = empty ? '0 : mem[top_idx];

   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         sp <= '0;
      else if (push && !full)
         sp <= sp + SW'(1);
      else if (pop && !empty)
         sp <= sp - SW'(1);
   end

   always_ff @(negedge clk) begin
      if (push && !full)
         mem[wr_idx] <= data_in;
   end

endmodule

// File: rtl/rpn_alu.sv
// Combinational RPN operator unit: y = b <op> a, where a is the former stack top.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = b + a;
         OP_SUB:  y = b - a;
         OP_AND:  y = b & a;
         OP_OR:   y = b | a;
         OP_XOR:  y = b ^ a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/rpn_sequencer.sv
// Reverse-Polish token sequencer: pushes operands, pops two entries per operator,
// pushes the result back, and reports results plus sticky error status.
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       tok_valid,
   output logic                       tok_ready,
   input  logic                       tok_is_op,
   input  logic [WIDTH-1:0]           tok_data,
   output logic                       stk_push,
   output logic                       stk_pop,
   output logic [WIDTH-1:0]           stk_din,
   input  logic [WIDTH-1:0]           stk_dout,
   input  logic                       stk_full,
   input  logic                       stk_empty,
   output logic                       res_valid,
   output logic [WIDTH-1:0]           res_data,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       err,
   output logic [1:0]                 err_code
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [2:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] opnd;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] alu_y;
   logic [2:0]       opcode;
   logic             accept;
   logic             new_err;
   logic [1:0]       new_code;

   assign opcode = tok_data[2:0];
   assign accept = tok_valid & tok_ready;

   assign tok_ready = (state == IDLE) & ~err;
   assign stk_push  = (state == PUSH_N) | (state == PUSH_R);
   assign stk_pop   = (state == POP_A)  | (state == POP_B);
   assign res_valid = (state == PUSH_R);
   assign stk_din   = (state == PUSH_N) ? opnd :
                      (state == PUSH_R) ? res_data : '0;

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (alu_y)
   );

   // Bad opcode is checked before underflow so an illegal operator never touches the stack.
   always_comb begin
      new_err  = 1'b0;
      new_code = ERR_NONE;
      if (accept) begin
         if (tok_is_op) begin
            if (!op_legal(opcode)) begin
               new_err  = 1'b1;
               new_code = ERR_BADOP;
            end else if (cnt < CW'(2) || stk_empty) begin
               new_err  = 1'b1;
               new_code = ERR_UNDER;
            end
         end else if (cnt == CW'(DEPTH) || stk_full) begin
            new_err  = 1'b1;
            new_code = ERR_OVER;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd     <= '0;
         op_q     <= OP_ADD;
         res_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && !new_err) begin
                  if (tok_is_op) begin
                     a_q   <= stk_dout;
                     op_q  <= opcode;
                     state <= POP_A;
                  end else begin
                     opnd  <= tok_data;
                     state <= PUSH_N;
                  end
               end
            end
            PUSH_N: begin
               cnt   <= cnt + CW'(1);
               state <= IDLE;
            end
            // The stack pops at the mid-cycle negedge, so stk_dout is already the second entry here.
            POP_A: begin
               b_q   <= stk_dout;
               cnt   <= cnt - CW'(1);
               state <= POP_B;
            end
            POP_B: begin
               res_data <= alu_y;
               cnt      <= cnt - CW'(1);
               state    <= PUSH_R;
            end
            PUSH_R: begin
               cnt   <= cnt + CW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (new_err) begin
         err      <= 1'b1;
         err_code <= new_code;
      end else if (clr) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end
   end

endmodule
